// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: datapath width, canonical NOP, base opcodes and
// the fetch-queue entry payload.
package rv_pipe_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with synchronous clear; head is read combinationally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full FIFO is only honoured when a pop frees the slot.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited in-order
// requests, buffers responses and drops wrong-path returns after a redirect.
module if_stage
  import rv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  output logic            id_flush
);

  localparam int unsigned CW  = $clog2(QDEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned EW  = $bits(fetch_entry_t);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_head;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   pc_count;
  logic [CW1-1:0]  credit_used;
  fetch_entry_t    q_head;
  fetch_entry_t    rsp_entry;
  logic            req_fire;
  logic            rsp_in;
  logic            rsp_kept;
  logic            q_pop;
  logic            q_push;
  logic            bypass;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Outstanding requests plus buffered entries never exceed the queue size,
  // so every response is guaranteed a slot.
  assign credit_used    = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < CW1'(QDEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_in    = imem_rsp_valid && (outstanding != '0);
  assign rsp_kept  = rsp_in && !redirect_valid && (drop_cnt == '0) && (pc_count != '0);
  assign q_pop     = !redirect_valid && !id_stall && (q_count != '0);
  assign bypass    = !redirect_valid && !id_stall && (q_count == '0) && rsp_kept;
  assign q_push    = rsp_kept && !bypass;
  assign rsp_entry = '{pc: pc_head, inst: imem_rsp_data};

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(QDEPTH)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_kept),
    .head      (pc_head),
    .count     (pc_count)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_fetch_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (q_push),
    .push_data (rsp_entry),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  // Fetch PC, in-flight count and wrong-path drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect_valid)  fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire)   fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_in);
      if (redirect_valid)                 drop_cnt <= outstanding - CW'(rsp_in);
      else if (rsp_in && drop_cnt != '0)  drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // Output register toward decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst       <= NOP_INST;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
      id_flush   <= 1'b0;
    end else begin
      id_flush <= redirect_valid;
      if (redirect_valid) begin
        inst       <= NOP_INST;
        inst_valid <= 1'b0;
      end else if (!id_stall) begin
        if (q_pop) begin
          inst       <= q_head.inst;
          inst_pc    <= q_head.pc;
          inst_valid <= 1'b1;
        end else if (bypass) begin
          inst       <= imem_rsp_data;
          inst_pc    <= pc_head;
          inst_valid <= 1'b1;
        end else begin
          inst       <= NOP_INST;
          inst_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage with an in-order instruction memory model.
module tb_if_stage;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int unsigned QDEPTH   = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    int unsigned due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_stall = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        id_flush;

  int          checks = 0;
  int          failures = 0;
  int          consumed = 0;
  int unsigned cyc = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  exp_t        sb[$];
  pend_t       pend[$];

  if_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .id_flush       (id_flush)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0] * 32'h9E37_79B1;
    return lo ^ a[63:32] ^ 32'h1234_5677;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic rv, input logic [63:0] rpc, input logic rdy);
    @(posedge clk); #1;
    id_stall       = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
  endtask

  // Instruction memory: accepts requests, returns memf(addr) in order after lat cycles.
  initial begin : memory
    logic [63:0] exp_addr;
    exp_addr = RESET_PC;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      @(negedge clk);
      if (rst) begin
        pend.delete();
        exp_addr = RESET_PC;
        continue;
      end
      if (redirect_valid) begin
        chk("req_blocked_by_redirect", 64'(imem_req_valid), 64'd0);
        exp_addr = {redirect_pc[63:2], 2'b00};
      end else if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_addr);
        sb.push_back('{pc: exp_addr, inst: memf(exp_addr)});
        pend.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
        chk("outstanding_bound", 64'(pend.size() <= QDEPTH), 64'd1);
        exp_addr = exp_addr + 64'd4;
      end
    end
  end

  // Monitor: consumes delivered instructions against the expected in-order stream.
  initial begin : monitor
    logic [31:0] p_inst;
    logic [63:0] p_pc;
    logic        p_valid, p_stall, p_redir, p_ok;
    exp_t        e;
    p_ok = 1'b0; p_redir = 1'b0; p_stall = 1'b0; p_valid = 1'b0; p_inst = '0; p_pc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        p_ok = 1'b0;
        p_redir = 1'b0;
        chk("rst_inst", 64'(inst), 64'(NOP));
        chk("rst_inst_pc", inst_pc, RESET_PC);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_id_flush", 64'(id_flush), 64'd0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        continue;
      end
      chk("id_flush", 64'(id_flush), 64'(p_redir));
      if (!inst_valid) chk("nop_when_invalid", 64'(inst), 64'(NOP));
      if (p_ok && p_stall && !p_redir) begin
        chk("stall_hold_inst", 64'(inst), 64'(p_inst));
        chk("stall_hold_pc", inst_pc, p_pc);
        chk("stall_hold_valid", 64'(inst_valid), 64'(p_valid));
      end
      if (inst_valid && !id_stall && !redirect_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_inst_pc", inst_pc, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          e = sb.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst", 64'(inst), 64'(e.inst));
          consumed++;
        end
      end
      if (redirect_valid) sb.delete();
      chk("buffered_bound", 64'(sb.size() <= QDEPTH + 1), 64'd1);
      p_inst = inst; p_pc = inst_pc; p_valid = inst_valid;
      p_stall = id_stall; p_redir = redirect_valid; p_ok = 1'b1;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [63:0] held_addr;
    logic [63:0] rpc;
    #2 rst = 1'b1;
    repeat (3) step(0, 0, 64'd0, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr", imem_req_addr, RESET_PC);

    // Full throughput with single-cycle memory.
    step(0, 0, 64'd0, 1);
    step(0, 0, 64'd0, 1);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 64'd0, 1);
      @(negedge clk);
      chk("throughput_valid", 64'(inst_valid), 64'd1);
    end

    // Stall until the queue fills; requests must stop.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 64'd0, 1);
      @(negedge clk);
      if (i >= 2) chk("full_stall_req_valid", 64'(imem_req_valid), 64'd0);
    end
    repeat (6) step(0, 0, 64'd0, 1);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    repeat (8) step(0, 0, 64'd0, 1);
    step(0, 1, 64'h100, 1);
    step(0, 0, 64'd0, 1);
    @(negedge clk);
    chk("redirect_nop_valid", 64'(inst_valid), 64'd0);
    chk("redirect_flush", 64'(id_flush), 64'd1);
    step(0, 0, 64'd0, 1);
    @(negedge clk);
    chk("redirect_flush_end", 64'(id_flush), 64'd0);
    repeat (10) step(0, 0, 64'd0, 1);

    // Redirect coinciding with a response, unaligned target.
    lat_min = 1; lat_max = 1;
    repeat (5) step(0, 0, 64'd0, 1);
    step(0, 1, 64'h203, 1);
    step(0, 0, 64'd0, 1);
    @(negedge clk);
    chk("redirect_aligned_addr", imem_req_addr, 64'h200);
    repeat (6) step(0, 0, 64'd0, 1);

    // Memory not ready for five cycles.
    step(0, 0, 64'd0, 0);
    @(negedge clk);
    held_addr = imem_req_addr;
    repeat (4) step(0, 0, 64'd0, 0);
    @(negedge clk);
    chk("notready_addr_stable", imem_req_addr, held_addr);
    chk("notready_inst_valid", 64'(inst_valid), 64'd0);
    chk("notready_inst_nop", 64'(inst), 64'(NOP));
    repeat (6) step(0, 0, 64'd0, 1);

    // Asynchronous reset in the middle of a stream.
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("midrst_inst", 64'(inst), 64'(NOP));
    chk("midrst_inst_pc", inst_pc, RESET_PC);
    chk("midrst_inst_valid", 64'(inst_valid), 64'd0);
    chk("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    repeat (2) step(0, 0, 64'd0, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("restart_req_addr", imem_req_addr, RESET_PC);

    // Randomized traffic, including redirects near the top of the address space.
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) lat_max = $urandom_range(4, 1);
      if ($urandom_range(9, 0) == 0)
        rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
      else
        rpc = 64'($urandom) & 64'hFFFF;
      step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 4, rpc,
           $urandom_range(99, 0) < 70);
    end
    repeat (20) step(0, 0, 64'd0, 1);
    @(negedge clk);
    chk("progress", 64'(consumed > 300), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 64-bit RISC-V five-stage pipeline; sits directly upstream of the decode stage and feeds it one 32-bit instruction plus its PC per cycle. Owns the fetch PC, issues in-order requests to instruction memory over a valid/ready handshake and buffers returned instructions in a small queue. Handles decode back-pressure and EX-stage redirects (branch/jump), discarding wrong-path responses still in flight. When no instruction is available it presents the canonical NOP (addi x0,x0,0).

## Interface
- XLEN, 64, data/address width
- RESET_PC, 64'h0, first fetch address after reset
- QDEPTH, 2, fetch-queue entries; also bounds outstanding requests

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- redirect_valid  in  1  EX requests PC redirect this cycle
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
- id_stall  in  1  decode cannot accept; hold outputs
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address, word aligned
- imem_rsp_valid  in  1  response valid (in order, ≥1 cycle after acceptance)
- imem_rsp_data  in  32  returned instruction
- inst  out  32  instruction to decode
- inst_pc  out  XLEN  PC of inst
- inst_valid  out  1  inst is a real fetched instruction
- id_flush  out  1  registered copy of redirect_valid; drives decode flush

## Operation
- fetch_pc register; imem_req_addr = fetch_pc. Request fires on imem_req_valid & imem_req_ready; fetch_pc += 4 (wraps modulo 2^XLEN).
- imem_req_valid = !rst & !redirect_valid & (outstanding + q_count < QDEPTH). Credit rule guarantees every response has a queue slot; responses are never back-pressured.
- PC FIFO: PC of each accepted request pushed at issue; popped when its response arrives, paired with imem_rsp_data into fetch queue.
- Output register (inst, inst_pc, inst_valid): when !id_stall, loads queue head (pop) or, if queue empty and a response arrives, the response directly (bypass). If neither: inst=32'h00000013, inst_pc unchanged, inst_valid=0. When id_stall: all three hold.
- Redirect (redirect_valid=1), takes priority over id_stall and responses:
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}; queue and PC FIFO cleared.
  - drop_cnt <= outstanding minus response accepted this cycle (response this cycle is discarded).
  - Output register <= NOP, inst_valid=0.
  - id_flush=1 next cycle.
- While drop_cnt>0, each response is discarded and drop_cnt decrements; outstanding decrements for every response, kept or dropped.
- Back-to-back redirects: latest target wins; drop_cnt recomputed from current outstanding.
- Environment requirement: instruction memory is reset by the same rst; no response arrives for a request accepted before reset.

## Timing
- Reset values: fetch_pc=RESET_PC, outstanding=0, drop_cnt=0, q_count=0, inst=32'h00000013, inst_pc=RESET_PC, inst_valid=0, id_flush=0, imem_req_valid=0 while rst high.
- First request: first cycle after rst deasserts.
- Latency: response at edge k (queue empty, no stall) -> inst/inst_valid visible after edge k.
- Throughput: one instruction/cycle with 1-cycle memory and QDEPTH=2.
- Redirect at edge k: new-target request issued earliest cycle after k; outputs NOP at k.
- Queue full (q_count=QDEPTH) with stall: imem_req_valid=0 until pop.
- Reset mid-operation: all state cleared asynchronously; queue content lost.

## Structure
- Shared package rv_pipe_pkg: XLEN, NOP_INST=32'h00000013, opcode constants (OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) shared with decode/execute.
- Sub-module fetch_fifo: parameterized synchronous FIFO (width, depth, clear input, count output); instantiated twice (PC FIFO, fetch queue).

## Test plan
- Reset release, 1-cycle memory, no stall -> requests at 0x0,0x4,0x8…; inst_pc 0x0,0x4,0x8 on consecutive cycles, inst_valid=1.
- id_stall high 3 cycles with queue full -> inst/inst_pc held, imem_req_valid=0, no instruction lost or duplicated after release.
- Redirect to 0x100 with 2 requests outstanding (3-cycle memory) -> both responses dropped, next inst_pc=0x100, id_flush pulses one cycle.
- Redirect and response same cycle, redirect_pc=0x203 -> response dropped, next request addr=0x200.
- imem_req_ready low 5 cycles -> outputs NOP, inst_valid=0, fetch_pc stable at pending address.
- rst asserted mid-stream -> outputs immediately NOP/inst_pc=RESET_PC/inst_valid=0; fetch restarts at RESET_PC.
